// File: rtl/db_req_arbiter.sv
// Two-port round-robin front end for an in-order lookup DB: issues one lookup per
// clock while credit remains and routes each in-order result back to its requester.
module db_req_arbiter #(
  parameter int KEY_SIZE        = 96,
  parameter int FLAG_SIZE       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [KEY_SIZE-1:0]                req0_key,
  input  logic [FLAG_SIZE-1:0]               req0_flag,
  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic [KEY_SIZE-1:0]                req1_key,
  input  logic [FLAG_SIZE-1:0]               req1_flag,
  input  logic                               req1_valid,
  output logic                               req1_ready,
  output logic                               resp0_valid,
  output logic                               resp1_valid,
  output logic [FLAG_SIZE-1:0]               resp_flag,
  output logic [KEY_SIZE-1:0]                db_key,
  output logic [FLAG_SIZE-1:0]               db_flag,
  output logic                               db_valid,
  input  logic                               db_out_valid,
  input  logic [FLAG_SIZE-1:0]               db_out_flag,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_underflow
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

  logic                  prio_q, prio_d;
  logic                  run_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [MAX_OUTSTANDING-1:0] idMem_q;
  logic                  resp0_q, resp1_q;
  logic [FLAG_SIZE-1:0]  respFlag_q;
  logic [KEY_SIZE-1:0]   dbKey_q;
  logic [FLAG_SIZE-1:0]  dbFlag_q;
  logic                  dbValid_q;

  logic gnt0, gnt1, hasCredit, hs0, hs1, hs, pop, headId;

  // run_q keeps ready low until the first edge after reset release.
  always_comb begin
    gnt1      = req1_valid & (~req0_valid | prio_q);
    gnt0      = req0_valid & ~gnt1;
    hasCredit = run_q & (cnt_q != FULL);
    hs0       = gnt0 & hasCredit;
    hs1       = gnt1 & hasCredit;
    hs        = hs0 | hs1;
    pop       = db_out_valid & (cnt_q != '0);
    headId    = idMem_q[rdPtr_q];

    prio_d = hs ? ~hs1 : prio_q;
    err_d  = err_q | (db_out_valid & (cnt_q == '0));
    cnt_d  = cnt_q;
    if (hs && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !hs) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      idMem_q    <= '0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
      respFlag_q <= '0;
      dbKey_q    <= '0;
      dbFlag_q   <= '0;
      dbValid_q  <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dbValid_q <= hs;
      if (hs) begin
        idMem_q[wrPtr_q] <= hs1;
        wrPtr_q          <= wrPtr_q + PW'(1);
        dbKey_q          <= hs1 ? req1_key : req0_key;
        dbFlag_q         <= hs1 ? req1_flag : req0_flag;
      end
      resp0_q <= pop & ~headId;
      resp1_q <= pop & headId;
      if (pop) begin
        rdPtr_q    <= rdPtr_q + PW'(1);
        respFlag_q <= db_out_flag;
      end
    end
  end

  assign req0_ready    = hs0;
  assign req1_ready    = hs1;
  assign resp0_valid   = resp0_q;
  assign resp1_valid   = resp1_q;
  assign resp_flag     = respFlag_q;
  assign db_key        = dbKey_q;
  assign db_flag       = dbFlag_q;
  assign db_valid      = dbValid_q;
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;

endmodule
